ebus_diag_responder: RTL and testbench

- EBUS-side diagnostic-function responder: the target end of the diag-strobe protocol that the front-end DTE initiates.
- Decodes the 7-bit diagnostic function code (ds) qualified by diagStrobe.
- Write functions: latches EBUS data into a local 8 x 36-bit diagnostic register file.
- Read functions: drives register or status contents onto EBUS data until the strobe drops.
- Instantiated on an EBOX board model; its driver outputs feed the EBUS wired-OR mux.

---
 rtl/ebus_diag_pkg.sv | 24 ++
 rtl/ebus_diag_if.sv | 46 ++++
 rtl/ebus_diag_strobe_sync.sv | 26 ++
 rtl/ebus_diag_responder.sv | 136 +++++++++++++
 tb/tb_ebus_diag_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ebus_diag_pkg.sv
// Shared types for the EBUS diagnostic-function responder.
// Optional parity feature is selected by the DIAG_PARITY_EN macro.
package ebus_diag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WDONE,
        RDRIVE,
        RHOLD
    } tDiagRspState;

    typedef logic [0:35] tDiagWord;
    typedef logic [0:6]  tDiagFn;

    localparam tDiagFn WR_BASE_DEF = 7'o040;
    localparam tDiagFn RD_BASE_DEF = 7'o100;

    // A base selects an 8-code block; only the top four bits are compared.
    function automatic logic fn_hit(tDiagFn ds, tDiagFn base);
        return ds[0:3] == base[0:3];
    endfunction

endpackage

// File: rtl/ebus_diag_if.sv
// Diag-strobe bus bundle between the DTE-side initiator and the responder.
// Parity signals exist only when DIAG_PARITY_EN is defined.
interface ebus_diag_if;
    import ebus_diag_pkg::*;

    tDiagFn      DS;
    logic        DIAG_STROBE;
    tDiagWord    EBUS_DATA_IN;
    tDiagWord    STATUS_IN;
    logic        EBUS_DRIVING;
    tDiagWord    EBUS_DATA_OUT;
    logic        WR_PULSE;
    logic [0:2]  WR_INDEX;
    logic [0:2]  DBG_SEL;
    tDiagWord    DBG_DATA;
    logic        ERR;
`ifdef DIAG_PARITY_EN
    logic        EBUS_PAR_IN;
    logic        EBUS_PAR_OUT;

    modport master (
        output DS, DIAG_STROBE, EBUS_DATA_IN, STATUS_IN, DBG_SEL,
        output EBUS_PAR_IN,
        input  EBUS_DRIVING, EBUS_DATA_OUT, WR_PULSE, WR_INDEX,
        input  DBG_DATA, ERR, EBUS_PAR_OUT
    );
    modport slave (
        input  DS, DIAG_STROBE, EBUS_DATA_IN, STATUS_IN, DBG_SEL,
        input  EBUS_PAR_IN,
        output EBUS_DRIVING, EBUS_DATA_OUT, WR_PULSE, WR_INDEX,
        output DBG_DATA, ERR, EBUS_PAR_OUT
    );
`else
    modport master (
        output DS, DIAG_STROBE, EBUS_DATA_IN, STATUS_IN, DBG_SEL,
        input  EBUS_DRIVING, EBUS_DATA_OUT, WR_PULSE, WR_INDEX,
        input  DBG_DATA, ERR
    );
    modport slave (
        input  DS, DIAG_STROBE, EBUS_DATA_IN, STATUS_IN, DBG_SEL,
        output EBUS_DRIVING, EBUS_DATA_OUT, WR_PULSE, WR_INDEX,
        output DBG_DATA, ERR
    );
`endif

endinterface

// File: rtl/ebus_diag_strobe_sync.sv
// Single-stage DIAG_STROBE register with rise detect.
module diag_strobe_sync (
    input  logic CLK,
    input  logic RESET_N,
    input  logic strobe_i,
    output logic strb_o,
    output logic rise_o
);

    logic strb_q;
    logic strb_q1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            strb_q  <= 1'b0;
            strb_q1 <= 1'b0;
        end else begin
            strb_q  <= strobe_i;
            strb_q1 <= strb_q;
        end
    end

    assign strb_o = strb_q;
    assign rise_o = strb_q & ~strb_q1;

endmodule

// File: rtl/ebus_diag_responder.sv
// EBUS-side diag-function responder: 8 x 36-bit register file, read/write FSM.
// Define DIAG_PARITY_EN to add EBUS_PAR_OUT / EBUS_PAR_IN handling.
module ebus_diag_responder
    import ebus_diag_pkg::*;
#(
    parameter tDiagFn WR_BASE   = WR_BASE_DEF,
    parameter tDiagFn RD_BASE   = RD_BASE_DEF,
    parameter int     SETUP_CYC = 2,
    parameter int     HOLD_CYC  = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    ebus_diag_if.slave  bus
);

    tDiagRspState state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [0:2]   idx_q, idx_d;
    logic         drive_q, drive_d;
    tDiagWord     data_q, data_d;
    logic         wr_pulse_q, wr_pulse_d;
    logic [0:2]   wr_index_q, wr_index_d;
    logic         err_q, err_d;
    logic         we;
    tDiagWord     regs_q [8];
    logic         strb;
    logic         rise;

    diag_strobe_sync u_sync (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .strobe_i (bus.DIAG_STROBE),
        .strb_o   (strb),
        .rise_o   (rise)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            drive_q    <= 1'b0;
            data_q     <= '0;
            wr_pulse_q <= 1'b0;
            wr_index_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            drive_q    <= drive_d;
            data_q     <= data_d;
            wr_pulse_q <= wr_pulse_d;
            wr_index_q <= wr_index_d;
            err_q      <= err_d;
            if (we) regs_q[idx_q] <= bus.EBUS_DATA_IN;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        drive_d    = drive_q;
        data_d     = data_q;
        wr_pulse_d = 1'b0;
        wr_index_d = wr_index_q;
        err_d      = err_q;
        we         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise && fn_hit(bus.DS, WR_BASE)) begin
                    state_d = WSETUP;
                    idx_d   = bus.DS[4:6];
                    cnt_d   = 4'(SETUP_CYC - 1);
                end else if (rise && fn_hit(bus.DS, RD_BASE)) begin
                    state_d = RDRIVE;
                    drive_d = 1'b1;
                    data_d  = (bus.DS[4:6] == 3'd7) ? bus.STATUS_IN
                                                    : regs_q[bus.DS[4:6]];
                end
            end
            WSETUP: begin
                cnt_d = cnt_q - 4'd1;
                if (!strb) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    we         = 1'b1;
                    wr_pulse_d = 1'b1;
                    wr_index_d = idx_q;
                    state_d    = WDONE;
`ifdef DIAG_PARITY_EN
                    if (!(^{bus.EBUS_DATA_IN, bus.EBUS_PAR_IN})) err_d = 1'b1;
`endif
                end
            end
            WDONE: begin
                if (!strb) state_d = IDLE;
            end
            RDRIVE: begin
                if (!strb && HOLD_CYC == 0) begin
                    state_d = IDLE;
                    drive_d = 1'b0;
                    data_d  = '0;
                end else if (!strb) begin
                    state_d = RHOLD;
                    cnt_d   = 4'(HOLD_CYC);
                end
            end
            RHOLD: begin
                // A new rise here is lost: RHOLD can only return to IDLE.
                if (rise) err_d = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = IDLE;
                    drive_d = 1'b0;
                    data_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.EBUS_DRIVING  = drive_q;
    assign bus.EBUS_DATA_OUT = data_q;
    assign bus.WR_PULSE      = wr_pulse_q;
    assign bus.WR_INDEX      = wr_index_q;
    assign bus.DBG_DATA      = regs_q[bus.DBG_SEL];
    assign bus.ERR           = err_q;
`ifdef DIAG_PARITY_EN
    assign bus.EBUS_PAR_OUT  = drive_q & ~(^data_q);
`endif

endmodule

// File: tb/tb_ebus_diag_responder.sv
// Directed bench for ebus_diag_responder (default parameters).
module tb_ebus_diag_responder;
    import ebus_diag_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int total = 0;
    int bad = 0;

    ebus_diag_if bus ();

    ebus_diag_responder dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

`ifdef DIAG_PARITY_EN
    assign bus.EBUS_PAR_IN = ~(^bus.EBUS_DATA_IN);
`endif

    localparam tDiagWord W_A = 36'o123456654321;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        bus.DIAG_STROBE = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        bus.DS = '0;
        bus.DIAG_STROBE = 1'b0;
        bus.EBUS_DATA_IN = '0;
        bus.STATUS_IN = '0;
        bus.DBG_SEL = '0;
        RESET_N = 1'b0;
        #23;
        total++;
        if (bus.EBUS_DRIVING !== 1'b0 || bus.EBUS_DATA_OUT !== 36'd0) begin
            bad++;
            $display("FAIL reset_drive: drv=%b data=%o want 0/0",
                     bus.EBUS_DRIVING, bus.EBUS_DATA_OUT);
        end
        total++;
        if (bus.WR_PULSE !== 1'b0 || bus.WR_INDEX !== 3'd0 ||
            bus.ERR !== 1'b0 || bus.DBG_DATA !== 36'd0) begin
            bad++;
            $display("FAIL reset_state: pulse=%b idx=%0d err=%b dbg=%o want 0",
                     bus.WR_PULSE, bus.WR_INDEX, bus.ERR, bus.DBG_DATA);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        idle(2);
    endtask

    task automatic test_write();
        logic exp_p;
        bus.DS = 7'o043;
        bus.EBUS_DATA_IN = W_A;
        bus.DIAG_STROBE = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) bus.DIAG_STROBE = 1'b0;
            exp_p = (k == 3);
            total++;
            if (bus.WR_PULSE !== exp_p || bus.EBUS_DRIVING !== 1'b0) begin
                bad++;
                $display("FAIL write_pulse k=%0d: pulse=%b drv=%b want %b/0",
                         k, bus.WR_PULSE, bus.EBUS_DRIVING, exp_p);
            end
            if (k == 3) begin
                total++;
                if (bus.WR_INDEX !== 3'd3) begin
                    bad++;
                    $display("FAIL write_index: got %0d want 3", bus.WR_INDEX);
                end
            end
        end
        bus.DBG_SEL = 3'd3;
        #1;
        total++;
        if (bus.DBG_DATA !== W_A) begin
            bad++;
            $display("FAIL write_dbg: got %o want %o", bus.DBG_DATA, W_A);
        end
        bus.EBUS_DATA_IN = '0;
        idle(2);
    endtask

    task automatic test_read(input tDiagFn fn, input int n, input tDiagWord w);
        logic exp_d;
        tDiagWord exp_w;
        bus.DS = fn;
        bus.DIAG_STROBE = 1'b1;
        for (int k = 1; k <= n + 5; k++) begin
            step();
            if (k == n) bus.DIAG_STROBE = 1'b0;
            if (k == 3) bus.DS = 7'o100;
            exp_d = (k >= 2 && k <= n + 2);
            exp_w = exp_d ? w : 36'd0;
            total++;
            if (bus.EBUS_DRIVING !== exp_d || bus.EBUS_DATA_OUT !== exp_w) begin
                bad++;
                $display("FAIL read_%o k=%0d: drv=%b data=%o want %b/%o",
                         fn, k, bus.EBUS_DRIVING, bus.EBUS_DATA_OUT, exp_d, exp_w);
            end
        end
        idle(2);
    endtask

    task automatic test_unmapped();
        bus.DS = 7'o070;
        bus.EBUS_DATA_IN = 36'o777777000000;
        bus.DIAG_STROBE = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3) bus.DIAG_STROBE = 1'b0;
            total++;
            if (bus.EBUS_DRIVING !== 1'b0 || bus.WR_PULSE !== 1'b0) begin
                bad++;
                $display("FAIL unmapped k=%0d: drv=%b pulse=%b want 0/0",
                         k, bus.EBUS_DRIVING, bus.WR_PULSE);
            end
        end
        total++;
        if (bus.ERR !== 1'b0 || bus.DBG_DATA !== W_A) begin
            bad++;
            $display("FAIL unmapped_state: err=%b dbg=%o want 0/%o",
                     bus.ERR, bus.DBG_DATA, W_A);
        end
        idle(2);
    endtask

    task automatic test_abort();
        bus.DS = 7'o040;
        bus.EBUS_DATA_IN = 36'o555555555555;
        bus.DBG_SEL = 3'd0;
        bus.DIAG_STROBE = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) bus.DIAG_STROBE = 1'b0;
            total++;
            if (bus.WR_PULSE !== 1'b0) begin
                bad++;
                $display("FAIL abort_pulse k=%0d: got %b want 0", k, bus.WR_PULSE);
            end
        end
        total++;
        if (bus.ERR !== 1'b1 || bus.DBG_DATA !== 36'd0) begin
            bad++;
            $display("FAIL abort_state: err=%b reg0=%o want 1/0",
                     bus.ERR, bus.DBG_DATA);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        bus.DS = 7'o103;
        bus.DBG_SEL = 3'd3;
        bus.DIAG_STROBE = 1'b1;
        step();
        step();
        total++;
        if (bus.EBUS_DRIVING !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: drv=%b want 1", bus.EBUS_DRIVING);
        end
        RESET_N = 1'b0;
        #1;
        total++;
        if (bus.EBUS_DRIVING !== 1'b0 || bus.EBUS_DATA_OUT !== 36'd0 ||
            bus.ERR !== 1'b0 || bus.DBG_DATA !== 36'd0) begin
            bad++;
            $display("FAIL rst_mid: drv=%b data=%o err=%b reg3=%o want 0",
                     bus.EBUS_DRIVING, bus.EBUS_DATA_OUT, bus.ERR, bus.DBG_DATA);
        end
        bus.DIAG_STROBE = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        idle(2);
    endtask

`ifdef DIAG_PARITY_EN
    task automatic test_parity();
        bus.DS = 7'o041;
        bus.EBUS_DATA_IN = 36'o1;
        bus.DIAG_STROBE = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        idle(3);
        bus.DS = 7'o101;
        bus.DIAG_STROBE = 1'b1;
        step();
        step();
        total++;
        if (bus.EBUS_DRIVING !== 1'b1 || bus.EBUS_PAR_OUT !== 1'b0 ||
            bus.ERR !== 1'b0) begin
            bad++;
            $display("FAIL parity: drv=%b par=%b err=%b want 1/0/0",
                     bus.EBUS_DRIVING, bus.EBUS_PAR_OUT, bus.ERR);
        end
        idle(5);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read(7'o103, 5, W_A);
        bus.STATUS_IN = 36'o777;
        test_read(7'o107, 2, 36'o777);
        test_unmapped();
        test_abort();
        test_reset_mid();
`ifdef DIAG_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
